// File: rtl/ecc_155_pkg.sv
// Shared definitions for the 155-bit SECDED code (8 Hamming bits + overall parity).
// Latency: n/a (constants, types and an elaboration-time mask generator only).
// Backpressure: n/a.
//
// Code layout: codeword positions 1..163, parity bits at powers of two, data bit i
// at the i-th non-power-of-two position starting from 3. Hamming bit k covers every
// data bit whose position has bit k set. Parity bit 8 is the even parity of the whole
// codeword (all data bits and all 8 Hamming bits). The decoder uses the same masks.
package ecc_155_pkg;

    localparam int DATA_WIDTH   = 155;
    localparam int PARITY_WIDTH = 9;
    localparam int HAM_WIDTH    = PARITY_WIDTH - 1;

    typedef logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] ham_mask_t;

    // Walks the data bits in codeword order and records, for each Hamming bit,
    // which data bits it covers. Evaluated only at elaboration.
    function automatic ham_mask_t gen_ham_masks();
        ham_mask_t  m;
        logic [7:0] pos;
        m   = '0;
        pos = 8'd2;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = pos + 8'd1;
            // Powers of two are parity positions; from 3 upward they are never adjacent.
            if ((pos & (pos - 8'd1)) == 8'd0) begin
                pos = pos + 8'd1;
            end
            for (int k = 0; k < HAM_WIDTH; k++) begin
                m[k][i] = pos[k];
            end
        end
        return m;
    endfunction

    localparam ham_mask_t HAM_MASKS = gen_ham_masks();

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [PARITY_WIDTH-1:0] parity;
        logic                    fault;
    } buf_entry_t;

endpackage

// File: rtl/ecc_155_enc_core.sv
// Purely combinational SECDED parity generator for one 155-bit word.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_data   [154:0] word to encode
//   o_parity [8:0]   {overall parity, Hamming bits [7:0]}
module ecc_155_enc_core
    import ecc_155_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic [PARITY_WIDTH-1:0] o_parity
);

    logic [HAM_WIDTH-1:0] w_ham;

    always_comb begin
        w_ham = '0;
        for (int k = 0; k < HAM_WIDTH; k++) begin
            w_ham[k] = ^(i_data & HAM_MASKS[k]);
        end
    end

    // Overall bit makes the full codeword (data + Hamming bits) even.
    assign o_parity = {(^i_data) ^ (^w_ham), w_ham};

endmodule

// File: rtl/ecc_155_wr_encoder.sv
// Write-side SECDED encoder with dual redundant cores, compare, and a 2-entry output buffer.
// Latency: 1 cycle from accept into an empty buffer to out_vld.
// Backpressure: valid/ready both sides; in_rdy is registered and drops once 2 entries are held.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ecc_fault_detc_en, bypass     per-beat controls, sampled on accept
//   in_vld/in_rdy/in_data         input beat
//   out_vld/out_rdy/out_data/out_parity/out_fault   output beat
//   fault_sticky, fault_cnt, fault_clr              retire-side fault accounting
//   inj_sbit, inj_dbit            error injection (only with ECC_155_ERR_INJ_EN defined)
// Optional feature macro: ECC_155_ERR_INJ_EN
module ecc_155_wr_encoder
    import ecc_155_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [PARITY_WIDTH-1:0] out_parity,
    output logic                    out_fault,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    input  logic                    fault_clr
`ifdef ECC_155_ERR_INJ_EN
    ,
    input  logic                    inj_sbit,
    input  logic                    inj_dbit
`endif
);

    logic [PARITY_WIDTH-1:0] w_parity0;
    logic [PARITY_WIDTH-1:0] w_parity1;
    logic                    w_acc;
    logic                    w_ret;
    logic                    w_mismatch;
    logic [1:0]              w_inj_mask;
    logic [1:0]              w_count_nxt;
    buf_entry_t              w_entry;
    buf_entry_t              w_head;

    buf_entry_t              r_mem [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;
    logic                    r_in_rdy;
    logic                    r_fault_sticky;
    logic [CNT_WIDTH-1:0]    r_fault_cnt;

    ecc_155_enc_core u0 (.i_data(in_data), .o_parity(w_parity0));
    ecc_155_enc_core u1 (.i_data(in_data), .o_parity(w_parity1));

    assign w_acc      = in_vld & r_in_rdy;
    assign w_ret      = out_vld & out_rdy;
    assign w_mismatch = |(w_parity0 ^ w_parity1);

`ifdef ECC_155_ERR_INJ_EN
    logic r_inj_sbit_q;
    logic r_inj_dbit_q;
    logic r_arm_sbit;
    logic r_arm_dbit;

    // An edge seen in the same cycle as an accept only arms; the beat accepted
    // now uses the previous arm state, so the flip lands on the following beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inj_sbit_q <= 1'b0;
            r_inj_dbit_q <= 1'b0;
            r_arm_sbit   <= 1'b0;
            r_arm_dbit   <= 1'b0;
        end else begin
            r_inj_sbit_q <= inj_sbit;
            r_inj_dbit_q <= inj_dbit;
            r_arm_sbit   <= (inj_sbit & ~r_inj_sbit_q) | (r_arm_sbit & ~w_acc);
            r_arm_dbit   <= (inj_dbit & ~r_inj_dbit_q) | (r_arm_dbit & ~w_acc);
        end
    end

    assign w_inj_mask = r_arm_dbit ? 2'b11 : (r_arm_sbit ? 2'b01 : 2'b00);
`else
    assign w_inj_mask = 2'b00;
`endif

    // Injection is applied after parity generation so the stored codeword is corrupt.
    always_comb begin
        w_entry        = '0;
        w_entry.data   = in_data ^ {{(DATA_WIDTH-2){1'b0}}, w_inj_mask};
        w_entry.parity = bypass ? '0 : w_parity0;
        w_entry.fault  = w_mismatch & ecc_fault_detc_en & ~bypass;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_acc && !w_ret) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_acc && w_ret) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_in_rdy <= 1'b1;
        end else begin
            if (w_acc) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_ret) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count  <= w_count_nxt;
            r_in_rdy <= (w_count_nxt != 2'd2);
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Clear has priority over a faulted beat retiring in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_sticky <= 1'b0;
            r_fault_cnt    <= '0;
        end else if (fault_clr) begin
            r_fault_sticky <= 1'b0;
            r_fault_cnt    <= '0;
        end else if (w_ret && w_head.fault) begin
            r_fault_sticky <= 1'b1;
            if (r_fault_cnt != '1) begin
                r_fault_cnt <= r_fault_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign in_rdy       = r_in_rdy;
    assign out_vld      = (r_count != 2'd0);
    assign out_data     = w_head.data;
    assign out_parity   = w_head.parity;
    assign out_fault    = w_head.fault;
    assign fault_sticky = r_fault_sticky;
    assign fault_cnt    = r_fault_cnt;

endmodule

// File: tb/tb_ecc_155_wr_encoder.sv
// Testbench for ecc_155_wr_encoder: scoreboard model with a positional SECDED
// encoder/decoder, directed sequences for handshake, fault, counter and reset behaviour.
// Injection sequences are included when ECC_155_ERR_INJ_EN is defined.
module tb_ecc_155_wr_encoder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ecc_fault_detc_en = 1'b1;
    logic         bypass = 1'b0;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [154:0] in_data = '0;
    logic         out_vld;
    logic         out_rdy = 1'b0;
    logic [154:0] out_data;
    logic [8:0]   out_parity;
    logic         out_fault;
    logic         fault_sticky;
    logic [7:0]   fault_cnt;
    logic         fault_clr = 1'b0;
    logic         inj_sbit = 1'b0;
    logic         inj_dbit = 1'b0;
    logic         force_on = 1'b0;

    int total = 0;
    int bad = 0;

    ecc_155_wr_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .ecc_fault_detc_en(ecc_fault_detc_en), .bypass(bypass),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_parity(out_parity), .out_fault(out_fault),
        .fault_sticky(fault_sticky), .fault_cnt(fault_cnt), .fault_clr(fault_clr)
`ifdef ECC_155_ERR_INJ_EN
        , .inj_sbit(inj_sbit), .inj_dbit(inj_dbit)
`endif
    );

    always #5 clk = ~clk;

    // Codeword position of each data bit (positions that are not powers of two).
    logic [7:0] dpos [155];

    function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Hamming bits = XOR of the positions of all set data bits; bit 8 evens the codeword.
    function automatic logic [8:0] enc(input logic [154:0] d);
        logic [7:0] syn;
        syn = 8'd0;
        for (int i = 0; i < 155; i++) if (d[i]) syn ^= dpos[i];
        return {(^d) ^ (^syn), syn};
    endfunction

    function automatic void dec(input logic [154:0] d, input logic [8:0] p,
                                output logic sb, output logic db, output logic [154:0] cd);
        logic [7:0] syn;
        logic       ov;
        syn = p[7:0];
        ov  = (^d) ^ (^p);
        for (int i = 0; i < 155; i++) if (d[i]) syn ^= dpos[i];
        sb = ov;
        db = !ov && (syn != 8'd0);
        cd = d;
        if (ov) for (int i = 0; i < 155; i++) if (dpos[i] == syn) cd[i] = ~cd[i];
    endfunction

    typedef struct {
        logic [154:0] d;
        logic [8:0]   p;
        logic         f;
        logic [154:0] orig;
        int           kind;   // 0 clean, 1 bypass, 2 single-bit injected, 3 double-bit injected
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;
    logic m_sticky = 1'b0;
    logic arm_s = 1'b0, arm_d = 1'b0, prev_s = 1'b0, prev_d = 1'b0;
    logic stall_prev = 1'b0;
    logic [154:0] sv_data;
    logic [8:0]   sv_par;
    logic         sv_flt;

    // Scoreboard: checks on the falling edge, then advances the model with the
    // handshakes that the next rising edge will commit.
    always @(negedge clk) begin : cmp
        logic acc, ret, sb, db;
        logic [154:0] cd;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0; m_sticky = 1'b0;
            arm_s = 1'b0; arm_d = 1'b0; prev_s = 1'b0; prev_d = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("out_vld", 160'(out_vld), 160'(q.size() != 0));
            chk("in_rdy", 160'(in_rdy), 160'(q.size() < 2));
            chk("fault_cnt", 160'(fault_cnt), 160'(m_cnt));
            chk("fault_sticky", 160'(fault_sticky), 160'(m_sticky));
            if (out_vld && q.size() != 0) begin
                chk("out_data", 160'(out_data), 160'(q[0].d));
                chk("out_parity", 160'(out_parity), 160'(q[0].p));
                chk("out_fault", 160'(out_fault), 160'(q[0].f));
                dec(out_data, out_parity, sb, db, cd);
                if (q[0].kind == 0) begin
                    chk("loop_err", 160'({sb, db}), 160'(2'b00));
                    chk("loop_data", 160'(cd), 160'(q[0].orig));
                end else if (q[0].kind == 2) begin
                    chk("inj_sbit_err", 160'(sb), 160'(1'b1));
                    chk("inj_corrected", 160'(cd), 160'(q[0].orig));
                end else if (q[0].kind == 3) begin
                    chk("inj_dbit_err", 160'(db), 160'(1'b1));
                end
            end
            if (stall_prev) begin
                chk("stall_stable", 160'({out_vld, out_data, out_parity, out_fault}),
                    160'({1'b1, sv_data, sv_par, sv_flt}));
            end
            acc = in_vld & in_rdy;
            ret = out_vld & out_rdy;
            if (fault_clr) begin
                m_cnt = 0; m_sticky = 1'b0;
            end else if (ret && q.size() != 0 && q[0].f) begin
                m_sticky = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (ret && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                e.orig = in_data; e.d = in_data; e.kind = 0;
                e.p = bypass ? 9'h000 : enc(in_data);
                e.f = force_on & ecc_fault_detc_en & ~bypass;
                if (arm_d) begin e.d[1:0] = ~e.d[1:0]; e.kind = 3; end
                else if (arm_s) begin e.d[0] = ~e.d[0]; e.kind = 2; end
                if (bypass) e.kind = 1;
                q.push_back(e);
                arm_s = 1'b0; arm_d = 1'b0;
            end
            if (inj_sbit && !prev_s) arm_s = 1'b1;
            if (inj_dbit && !prev_d) arm_d = 1'b1;
            prev_s = inj_sbit; prev_d = inj_dbit;
            stall_prev = out_vld & ~out_rdy;
            sv_data = out_data; sv_par = out_parity; sv_flt = out_fault;
        end
    end

    function automatic logic [154:0] rnd();
        return 155'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Presents one beat and holds it until accepted (bounded); returns 2 time
    // units after the accepting edge. With rnd set, out_rdy is randomised per cycle.
    task automatic send(input logic [154:0] d, input bit rnd_rdy);
        bit done;
        done = 1'b0;
        in_vld = 1'b1;
        in_data = d;
        for (int n = 0; n < 60 && !done; n++) begin
            if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_rdy) done = 1'b1;
            @(posedge clk);
            #2;
        end
        in_vld = 1'b0;
        if (!done) chk("send_timeout", 160'(0), 160'(1));
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        out_rdy = 1'b1;
        for (int n = 0; n < 20 && !empty; n++) begin
            @(posedge clk);
            #2;
            if (!out_vld) empty = 1'b1;
        end
        if (!empty) chk("drain_timeout", 160'(0), 160'(1));
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] p;
        int         n;
        logic [154:0] a, b, c;
        p = 8'd2;
        n = 0;
        while (n < 155) begin
            p = p + 8'd1;
            if ((p & (p - 8'd1)) != 8'd0) begin
                dpos[n] = p;
                n++;
            end
        end

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_vld", 160'(out_vld), 160'(0));
        chk("rst_in_rdy", 160'(in_rdy), 160'(1));
        chk("rst_out_data", 160'(out_data), 160'(0));
        chk("rst_out_parity", 160'(out_parity), 160'(0));
        chk("rst_out_fault", 160'(out_fault), 160'(0));
        chk("rst_sticky", 160'(fault_sticky), 160'(0));
        chk("rst_cnt", 160'(fault_cnt), 160'(0));
        rst_n = 1'b1;
        cycle();

        // Hand-computed parities and one-cycle latency
        out_rdy = 1'b0;
        send(155'h0, 1'b0);
        chk("lat_out_vld", 160'(out_vld), 160'(1));
        chk("par_zero", 160'(out_parity), 160'(9'h000));
        drain();
        out_rdy = 1'b0;
        send(155'h1, 1'b0);
        chk("par_bit0", 160'(out_parity), 160'(9'h103));
        drain();
        out_rdy = 1'b0;
        send(155'h8, 1'b0);
        chk("par_bit3", 160'(out_parity), 160'(9'h007));
        drain();

        // Loopback: all-ones then random words with random downstream stalls
        send({155{1'b1}}, 1'b0);
        for (int i = 0; i < 1000; i++) send(rnd(), 1'b1);
        drain();

        // Bypass beats store zero parity and never flag a fault
        bypass = 1'b1;
        for (int i = 0; i < 5; i++) send(rnd(), 1'b0);
        bypass = 1'b0;
        drain();

        // Backpressure: third beat held, order A,B,C, outputs stable while stalled
        a = rnd(); b = rnd(); c = rnd();
        out_rdy = 1'b0;
        send(a, 1'b0);
        send(b, 1'b0);
        chk("bp_in_rdy_drop", 160'(in_rdy), 160'(0));
        in_vld = 1'b1;
        in_data = c;
        repeat (3) cycle();
        chk("bp_in_rdy_held", 160'(in_rdy), 160'(0));
        chk("bp_head_is_a", 160'(out_data), 160'(a));
        out_rdy = 1'b1;
        send(c, 1'b0);
        drain();

        // Fault force suppressed by disabled compare and by bypass
        force_on = 1'b1;
        force dut.w_parity1 = 9'h008;
        ecc_fault_detc_en = 1'b0;
        send(155'h0, 1'b0);
        ecc_fault_detc_en = 1'b1;
        bypass = 1'b1;
        send(155'h0, 1'b0);
        bypass = 1'b0;
        release dut.w_parity1;
        force_on = 1'b0;
        drain();
        chk("supp_cnt", 160'(fault_cnt), 160'(0));
        chk("supp_sticky", 160'(fault_sticky), 160'(0));

        // Fault force on a single beat
        force_on = 1'b1;
        force dut.w_parity1 = 9'h008;
        send(155'h0, 1'b0);
        release dut.w_parity1;
        force_on = 1'b0;
        send(155'h0, 1'b0);
        drain();
        chk("fault_cnt_one", 160'(fault_cnt), 160'(1));
        chk("fault_sticky_one", 160'(fault_sticky), 160'(1));

        // Saturation after 260 more faulted beats
        force_on = 1'b1;
        force dut.w_parity1 = 9'h008;
        for (int i = 0; i < 260; i++) send(155'h0, 1'b0);
        drain();
        chk("sat_cnt", 160'(fault_cnt), 160'(255));

        // Clear wins against a faulted beat retiring in the same cycle
        out_rdy = 1'b0;
        send(155'h0, 1'b0);
        release dut.w_parity1;
        force_on = 1'b0;
        fault_clr = 1'b1;
        out_rdy = 1'b1;
        cycle();
        fault_clr = 1'b0;
        chk("clr_cnt", 160'(fault_cnt), 160'(0));
        chk("clr_sticky", 160'(fault_sticky), 160'(0));
        chk("clr_retired", 160'(out_vld), 160'(0));

        // Reset with two entries buffered
        out_rdy = 1'b0;
        send(rnd(), 1'b0);
        send(rnd(), 1'b0);
        #1 rst_n = 1'b0;
        #1 chk("arst_out_vld", 160'(out_vld), 160'(0));
        cycle();
        rst_n = 1'b1;
        chk("arst_in_rdy", 160'(in_rdy), 160'(1));
        out_rdy = 1'b1;
        repeat (4) cycle();
        chk("arst_no_stale", 160'(out_vld), 160'(0));

`ifdef ECC_155_ERR_INJ_EN
        // Injection: sbit, dbit, and arming coincident with an accept
        out_rdy = 1'b1;
        inj_sbit = 1'b1;
        cycle();
        inj_sbit = 1'b0;
        send(rnd(), 1'b0);
        send(rnd(), 1'b0);
        inj_dbit = 1'b1;
        cycle();
        inj_dbit = 1'b0;
        send(rnd(), 1'b0);
        send(rnd(), 1'b0);
        inj_sbit = 1'b1;
        send(rnd(), 1'b0);
        inj_sbit = 1'b0;
        send(rnd(), 1'b0);
        send(rnd(), 1'b0);
        drain();
`endif

        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
